iq_comp_pipe: RTL and testbench

Parametrised, pipelined successor to the blind IQ-imbalance compensator in the receiver baseband, sitting between the ADC sample path and the demodulator. Applies y = x + w·conj(x) to offset-binary I/Q samples and adapts complex weight w by LMS (w ← w − μ·y²). Adds an input/output valid handshake, generic widths, a seeded-adaptive mode and a windowed settled detector.

---
 rtl/iq_comp_pipe.sv | 253 +++++++++++++++++++++++++
 tb/tb_iq_comp_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_comp_pipe.sv
// -----------------------------------------------------------------------------
// iq_comp_pipe
//
// Blind IQ-imbalance compensator with LMS adaptation. It sits between the ADC
// sample path and the demodulator.
//   y = x + w * conj(x)
//   w <- w - mu * y^2
// Samples arrive in offset binary and leave in two's complement. The pipeline
// has two register stages: input conversion, then compensation.
//
// Optional build macro:
//   IQ_COMP_ROUND_EN  When defined, every arithmetic right shift (FRAC and
//                     MU_SHIFT) rounds half-up. When undefined, every shift
//                     floors.
//
// Ports:
//   clk            sample clock
//   RESET          asynchronous reset, active high
//   in_valid       Ix/Qx are valid this cycle
//   Ix, Qx         offset-binary input samples, DATA_W bits
//   op_mode        00 bypass, 01 adapt, 10 fixed, 11 seeded adapt
//   freeze_iqcomp  holds the adaptive weights and the settle counter
//   Wr_in, Wj_in   external or seed weights, signed W_W bits
//   out_valid      Iy/Qy are valid
//   Iy, Qy         compensated samples, signed DATA_W bits
//   Wr, Wj         current weights, signed W_W bits
//   settled        SETTLE_LEN consecutive quiet updates have been seen
// -----------------------------------------------------------------------------
module iq_comp_pipe #(
  parameter int DATA_W     = 4,
  parameter int W_W        = 13,
  parameter int FRAC       = 10,
  parameter int MU_SHIFT   = 2,
  parameter int SETTLE_TOL = 0,
  parameter int SETTLE_LEN = 256
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     in_valid,
  input  logic        [DATA_W-1:0] Ix,
  input  logic        [DATA_W-1:0] Qx,
  input  logic        [1:0]        op_mode,
  input  logic                     freeze_iqcomp,
  input  logic signed [W_W-1:0]    Wr_in,
  input  logic signed [W_W-1:0]    Wj_in,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] Iy,
  output logic signed [DATA_W-1:0] Qy,
  output logic signed [W_W-1:0]    Wr,
  output logic signed [W_W-1:0]    Wj,
  output logic                     settled
);

  // Internal widths. The products are kept at full precision. Each width has
  // headroom for the sum of two products and for the rounding offset.
  localparam int PW = W_W + DATA_W;      // one weight * sample product
  localparam int AW = W_W + DATA_W + 2;  // sum of two products plus the sample
  localparam int UW = 2 * DATA_W + 2;    // y^2 terms for the LMS step
  localparam int MW = W_W + UW;          // weight minus step, before saturation
  localparam int CW = $clog2(SETTLE_LEN + 1);

  localparam logic signed [AW-1:0] D_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] D_MIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [MW-1:0] W_MAX = {{(MW-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
  localparam logic signed [MW-1:0] W_MIN = {{(MW-W_W+1){1'b1}}, {(W_W-1){1'b0}}};
  localparam logic signed [UW-1:0] TOL_S = UW'(SETTLE_TOL);
  localparam logic        [CW-1:0] LEN_C = CW'(SETTLE_LEN);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_ADAPT  = 2'b01,
    MODE_FIXED  = 2'b10,
    MODE_SEEDED = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // Shift and saturation helpers
  // ---------------------------------------------------------------------------
`ifdef IQ_COMP_ROUND_EN
  localparam logic signed [AW-1:0] RND_F  = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [UW-1:0] RND_MU = {{(UW-MU_SHIFT){1'b0}}, 1'b1, {(MU_SHIFT-1){1'b0}}};

  function automatic logic signed [AW-1:0] shr_frac(input logic signed [AW-1:0] v);
    return (v + RND_F) >>> FRAC;
  endfunction

  function automatic logic signed [UW-1:0] shr_mu(input logic signed [UW-1:0] v);
    return (v + RND_MU) >>> MU_SHIFT;
  endfunction
`else
  function automatic logic signed [AW-1:0] shr_frac(input logic signed [AW-1:0] v);
    return v >>> FRAC;
  endfunction

  function automatic logic signed [UW-1:0] shr_mu(input logic signed [UW-1:0] v);
    return v >>> MU_SHIFT;
  endfunction
`endif

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] r;
    if (v > D_MAX)      r = D_MAX;
    else if (v < D_MIN) r = D_MIN;
    else                r = v;
    return r[DATA_W-1:0];
  endfunction

  function automatic logic signed [W_W-1:0] sat_weight(input logic signed [MW-1:0] v);
    logic signed [MW-1:0] r;
    if (v > W_MAX)      r = W_MAX;
    else if (v < W_MIN) r = W_MIN;
    else                r = v;
    return r[W_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: offset binary to two's complement (invert the MSB)
  // ---------------------------------------------------------------------------
  mode_e                     mode;
  logic signed [DATA_W-1:0]  xi_d, xq_d, xi_q, xq_q;
  logic                      s1_valid_q;

  assign mode = mode_e'(op_mode);
  assign xi_d = {~Ix[DATA_W-1], Ix[DATA_W-2:0]};
  assign xq_d = {~Qx[DATA_W-1], Qx[DATA_W-2:0]};

  // NOTE: clocked state uses non-blocking assignments. Every register then
  // samples the values that were present before the edge, so the order in
  // which these blocks appear does not matter.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      s1_valid_q <= 1'b0;
      xi_q       <= '0;
      xq_q       <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        xi_q <= xi_d;
        xq_q <= xq_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: compensation using the current (registered) weights
  // ---------------------------------------------------------------------------
  logic signed [W_W-1:0]    wr_q, wj_q, wr_d, wj_d;
  logic signed [PW-1:0]     p_ri, p_jq, p_ji, p_rq;
  logic signed [AW-1:0]     acc_i, acc_q, y_i_wide, y_q_wide;
  logic signed [DATA_W-1:0] iy_d, qy_d, iy_q, qy_q;
  logic                     out_valid_q;

  assign p_ri = PW'(wr_q) * PW'(xi_q);
  assign p_jq = PW'(wj_q) * PW'(xq_q);
  assign p_ji = PW'(wj_q) * PW'(xi_q);
  assign p_rq = PW'(wr_q) * PW'(xq_q);

  // The conjugate flips the sign of xQ, so Wr enters the Q path negated.
  assign acc_i    = AW'(p_ri) + AW'(p_jq);
  assign acc_q    = AW'(p_ji) - AW'(p_rq);
  assign y_i_wide = AW'(xi_q) + shr_frac(acc_i);
  assign y_q_wide = AW'(xq_q) + shr_frac(acc_q);

  assign iy_d = (mode == MODE_BYPASS) ? xi_q : sat_data(y_i_wide);
  assign qy_d = (mode == MODE_BYPASS) ? xq_q : sat_data(y_q_wide);

  // The outputs hold their last value through bubbles.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      iy_q        <= '0;
      qy_q        <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        iy_q <= iy_d;
        qy_q <= qy_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // LMS weight update driven by the registered outputs
  // ---------------------------------------------------------------------------
  mode_e                 prev_mode_q;
  logic                  seed_load, do_update, mode_change, quiet;
  logic signed [UW-1:0]  sq_i, sq_q, prod_iq, diff_r, two_iq, d_r, d_j;
  logic        [CW-1:0]  cnt_q, cnt_d;

  assign mode_change = (mode != prev_mode_q);
  // A seed load happens only on the first clock of a mode-11 run. It takes
  // priority over the adaptive step on that clock.
  assign seed_load   = (mode == MODE_SEEDED) && (prev_mode_q != MODE_SEEDED);
  assign do_update   = ((mode == MODE_ADAPT) || (mode == MODE_SEEDED)) &&
                       !freeze_iqcomp && out_valid_q && !seed_load;

  assign sq_i    = UW'(iy_q) * UW'(iy_q);
  assign sq_q    = UW'(qy_q) * UW'(qy_q);
  assign prod_iq = UW'(iy_q) * UW'(qy_q);
  assign diff_r  = sq_i - sq_q;
  assign two_iq  = prod_iq + prod_iq;
  assign d_r     = shr_mu(diff_r);
  assign d_j     = shr_mu(two_iq);
  assign quiet   = (d_r <= TOL_S) && (d_r >= -TOL_S) &&
                   (d_j <= TOL_S) && (d_j >= -TOL_S);

  // NOTE: every signal driven here gets a default value first. A path that
  // left one of them unassigned would infer a latch.
  always_comb begin
    wr_d  = wr_q;
    wj_d  = wj_q;
    cnt_d = cnt_q;

    if ((mode == MODE_FIXED) || seed_load) begin
      wr_d = Wr_in;
      wj_d = Wj_in;
    end else if (do_update) begin
      wr_d = sat_weight(MW'(wr_q) - MW'(d_r));
      wj_d = sat_weight(MW'(wj_q) - MW'(d_j));
    end

    // A mode change or a non-adaptive mode restarts the settle window.
    // Freeze holds the counter only while it is still meaningful.
    if (mode_change || (mode == MODE_BYPASS) || (mode == MODE_FIXED)) begin
      cnt_d = '0;
    end else if (do_update) begin
      if (!quiet)              cnt_d = '0;
      else if (cnt_q != LEN_C) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_q        <= '0;
      wj_q        <= '0;
      cnt_q       <= '0;
      prev_mode_q <= MODE_BYPASS;
    end else begin
      wr_q        <= wr_d;
      wj_q        <= wj_d;
      cnt_q       <= cnt_d;
      prev_mode_q <= mode;
    end
  end

  assign out_valid = out_valid_q;
  assign Iy        = iy_q;
  assign Qy        = qy_q;
  assign Wr        = wr_q;
  assign Wj        = wj_q;
  assign settled   = (cnt_q == LEN_C);

endmodule

// File: tb/tb_iq_comp_pipe.sv
// -----------------------------------------------------------------------------
// tb_iq_comp_pipe
//
// Self-checking bench for iq_comp_pipe with the default parameters and the
// floor-shift build. Each sample driven pushes its expected Iy/Qy onto a
// queue. A monitor pops and compares one entry whenever out_valid is seen.
// Each scenario task also checks weights, settled and timing inline.
// -----------------------------------------------------------------------------
module tb_iq_comp_pipe;

  logic               clk = 1'b0;
  logic               RESET;
  logic               in_valid;
  logic        [3:0]  Ix, Qx;
  logic        [1:0]  op_mode;
  logic               freeze_iqcomp;
  logic signed [12:0] Wr_in, Wj_in;
  logic               out_valid;
  logic signed [3:0]  Iy, Qy;
  logic signed [12:0] Wr, Wj;
  logic               settled;

  // Two's complement codes for the negative weights used below.
  localparam logic signed [12:0] W_P1024 = 13'sh0400;
  localparam logic signed [12:0] W_M4095 = 13'sh1001;
  localparam logic signed [12:0] W_M4096 = 13'sh1000;
  localparam logic signed [12:0] W_M2    = 13'sh1FFE;
  localparam logic signed [12:0] W_M1    = 13'sh1FFF;

  typedef struct {
    logic signed [3:0] i;
    logic signed [3:0] q;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  iq_comp_pipe dut (
    .clk           (clk),
    .RESET         (RESET),
    .in_valid      (in_valid),
    .Ix            (Ix),
    .Qx            (Qx),
    .op_mode       (op_mode),
    .freeze_iqcomp (freeze_iqcomp),
    .Wr_in         (Wr_in),
    .Wj_in         (Wj_in),
    .out_valid     (out_valid),
    .Iy            (Iy),
    .Qy            (Qy),
    .Wr            (Wr),
    .Wj            (Wj),
    .settled       (settled)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (RESET === 1'b0 && out_valid === 1'b1) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: out_valid with Iy=%0d Qy=%0d, no sample expected", Iy, Qy);
      end else begin
        e = sb.pop_front();
        if (Iy !== e.i || Qy !== e.q) begin
          n_fail++;
          $display("FAIL sb_sample: got Iy=%0d Qy=%0d, expected Iy=%0d Qy=%0d", Iy, Qy, e.i, e.q);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ei, input int eq);
    exp_t e;
    e.i = ei[3:0];
    e.q = eq[3:0];
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] ix, input logic [3:0] qx, input int ei, input int eq);
    in_valid = 1'b1;
    Ix       = ix;
    Qx       = qx;
    push_exp(ei, eq);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    in_valid      = 1'b0;
    freeze_iqcomp = 1'b0;
    op_mode       = 2'b00;
    RESET         = 1'b1;
    #3;
    RESET         = 1'b0;
    sb.delete();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (Iy !== 4'sd0 || Qy !== 4'sd0) begin n_fail++; $display("FAIL reset_iq: got Iy=%0d Qy=%0d want 0 0", Iy, Qy); end
    n_checks++;
    if (Wr !== 13'sd0 || Wj !== 13'sd0) begin n_fail++; $display("FAIL reset_weights: got Wr=%0d Wj=%0d want 0 0", Wr, Wj); end
    n_checks++;
    if (settled !== 1'b0) begin n_fail++; $display("FAIL reset_settled: got %b want 0", settled); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_fixed();
    op_mode = 2'b10;
    Wr_in   = W_P1024;
    Wj_in   = 13'sd0;
    tick();
    n_checks++;
    if (Wr !== W_P1024 || Wj !== 13'sd0) begin n_fail++; $display("FAIL fixed_load: got Wr=%0d Wj=%0d want 1024 0", Wr, Wj); end
    // xI=4, xQ=2: Iy = 4 + 4 saturates to 7; Qy = 2 - 2 = 0.
    drive(4'hC, 4'hA, 7, 0);
    tick();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_bypass();
    op_mode = 2'b00;
    Wr_in   = 13'sd0;
    drive(4'hC, 4'h5, 4, -3);
    tick();
    idle();
    tick();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_latency: got out_valid=%b want 1", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || Iy !== 4'sd4 || Qy !== -4'sd3) begin
      n_fail++;
      $display("FAIL bypass_hold: got v=%b Iy=%0d Qy=%0d want 0 4 -3", out_valid, Iy, Qy);
    end
    n_checks++;
    if (Wr !== W_P1024 || Wj !== 13'sd0) begin n_fail++; $display("FAIL bypass_weights: got Wr=%0d Wj=%0d want 1024 0", Wr, Wj); end
  endtask

  task automatic test_adapt();
    apply_reset();
    op_mode = 2'b01;
    Wr_in   = 13'sd0;
    Wj_in   = 13'sd0;
    repeat (2) tick();
    drive(4'hB, 4'h9, 3, 1);
    tick();
    idle();
    tick();
    n_checks++;
    if (Wr !== 13'sd0 || Wj !== 13'sd0) begin n_fail++; $display("FAIL adapt_pre: got Wr=%0d Wj=%0d want 0 0", Wr, Wj); end
    tick();
    // dR = (9 - 1) >>> 2 = 2, dJ = 6 >>> 2 = 1.
    n_checks++;
    if (Wr !== W_M2 || Wj !== W_M1) begin n_fail++; $display("FAIL adapt_step: got Wr=%0d Wj=%0d want -2 -1", Wr, Wj); end
    freeze_iqcomp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      // W=(-2,-1): Iy = 3 + floor(-7/1024) = 2, Qy = 1 + floor(-1/1024) = 0.
      drive(4'hB, 4'h9, 2, 0);
      tick();
    end
    idle();
    repeat (3) tick();
    n_checks++;
    if (Wr !== W_M2 || Wj !== W_M1) begin n_fail++; $display("FAIL adapt_freeze: got Wr=%0d Wj=%0d want -2 -1", Wr, Wj); end
    freeze_iqcomp = 1'b0;
  endtask

  task automatic test_seeded_sat();
    apply_reset();
    op_mode = 2'b11;
    Wr_in   = W_M4095;
    Wj_in   = 13'sd0;
    tick();
    n_checks++;
    if (Wr !== W_M4095 || Wj !== 13'sd0) begin n_fail++; $display("FAIL seed_load: got Wr=%0d Wj=%0d want -4095 0", Wr, Wj); end
    // xI=7, xQ=0: Iy = 7 + floor(-28665/1024) = -21, which saturates to -8.
    for (int k = 0; k < 20; k++) begin
      drive(4'hF, 4'h8, -8, 0);
      tick();
      n_checks++;
      if (Wr !== W_M4095 && Wr !== W_M4096) begin
        n_fail++;
        $display("FAIL seed_nowrap: cycle %0d got Wr=%0d want -4095 or -4096", k, Wr);
      end
    end
    idle();
    repeat (3) tick();
    n_checks++;
    if (Wr !== W_M4096 || Wj !== 13'sd0) begin n_fail++; $display("FAIL seed_sat: got Wr=%0d Wj=%0d want -4096 0", Wr, Wj); end
  endtask

  task automatic test_settled();
    int  updates = 0;
    bit  ov;
    bit  reached = 1'b0;
    apply_reset();
    op_mode = 2'b01;
    repeat (2) tick();
    for (int c = 0; c < 400 && !reached; c++) begin
      drive(4'h8, 4'h8, 0, 0);
      ov = out_valid;
      tick();
      if (ov) updates++;
      if (updates == 255 && ov) begin
        n_checks++;
        if (settled !== 1'b0) begin n_fail++; $display("FAIL settle_early: got settled=%b after 255 updates want 0", settled); end
      end
      if (updates == 256) begin
        reached = 1'b1;
        n_checks++;
        if (settled !== 1'b1) begin n_fail++; $display("FAIL settle_rise: got settled=%b after 256 updates want 1", settled); end
      end
    end
    if (!reached) begin
      n_checks++;
      n_fail++;
      $display("FAIL settle_timeout: only %0d updates seen, want 256", updates);
    end
    op_mode = 2'b00;
    drive(4'h8, 4'h8, 0, 0);
    tick();
    n_checks++;
    if (settled !== 1'b0) begin n_fail++; $display("FAIL settle_clear: got settled=%b after mode change want 0", settled); end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset_midop();
    apply_reset();
    op_mode = 2'b10;
    Wr_in   = W_P1024;
    Wj_in   = 13'sd0;
    tick();
    // xI=4, xQ=-3 with Wr=1024: Iy = 8 saturates to 7, Qy = -3 + 3 = 0.
    for (int k = 0; k < 4; k++) begin
      drive(4'hC, 4'h5, 7, 0);
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midop_stream: got out_valid=%b want 1", out_valid); end
    #2;
    RESET = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || Iy !== 4'sd0 || Qy !== 4'sd0) begin
      n_fail++;
      $display("FAIL midop_async_out: got v=%b Iy=%0d Qy=%0d want 0 0 0", out_valid, Iy, Qy);
    end
    n_checks++;
    if (Wr !== 13'sd0 || Wj !== 13'sd0 || settled !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_async_w: got Wr=%0d Wj=%0d settled=%b want 0 0 0", Wr, Wj, settled);
    end
    sb.delete();
    idle();
    op_mode = 2'b00;
    #2;
    RESET = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_flush: got out_valid=%b want 0", out_valid); end
    drive(4'hC, 4'h5, 4, -3);
    tick();
    idle();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_early: got out_valid=%b one edge after input want 0", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midop_latency: got out_valid=%b two edges after input want 1", out_valid); end
    repeat (2) tick();
  endtask

  initial begin
    RESET         = 1'b1;
    in_valid      = 1'b0;
    Ix            = 4'h8;
    Qx            = 4'h8;
    op_mode       = 2'b00;
    freeze_iqcomp = 1'b0;
    Wr_in         = 13'sd0;
    Wj_in         = 13'sd0;

    test_reset();
    test_fixed();
    test_bypass();
    test_adapt();
    test_seeded_sat();
    test_settled();
    test_reset_midop();

    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d expected samples never appeared", sb.size()); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
